da_unloader: RTL

Drains one 8-entry frame from the da_regfile register file and presents it as a valid/ready stream.
- On a start pulse it issues sequential reads on addresses 0..7.
- It absorbs the register file's 1-cycle read latency in a 2-entry buffer, so downstream backpressure never loses or duplicates a sample.
- It sits between the regfile read port and the next FFT stage or output interface.

---
 rtl/da_pkg.sv | 22 ++
 rtl/da_skid_fifo.sv | 54 +++++
 rtl/da_unloader.sv | 119 +++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared widths, unloader state and beat record for the frame unloader
package da_pkg;

  localparam int DATA_WIDTH = 17;
  localparam int N_POINT    = 8;
  localparam int ADDR_WIDTH = 3;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_POINT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
    logic [ADDR_WIDTH-1:0] idx;
  } beat_t;

endpackage

// File: rtl/da_skid_fifo.sv
// rtl/da_skid_fifo.sv - 2-entry beat buffer absorbing the regfile read latency
module da_skid_fifo
  import da_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  beat_t      din_i,
  output beat_t      head_o,
  output logic [1:0] count_o,
  output logic       empty_o
);

  beat_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
      end
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_q ^ pop_i;
      count_q  <= count_d;
    end
  end

  // The upstream credit rule must keep a push away from a full buffer.
  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      assert (!(push_i && count_q == 2'd2));
      assert (!(pop_i && count_q == 2'd0));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/da_unloader.sv
// rtl/da_unloader.sv - drains an 8-entry regfile frame onto a valid/ready stream
module da_unloader
  import da_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_ren,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_dout_real,
  input  logic [DATA_WIDTH-1:0] rf_dout_imag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_real,
  output logic [DATA_WIDTH-1:0] m_imag,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] tag_q;
  logic                  inflight_q;
  logic                  done_q;

  beat_t                 push_beat;
  beat_t                 head;
  logic [1:0]            occ;
  logic                  empty;
  logic                  pop;
  logic [2:0]            credit_sum;
  logic                  issue_ok;
  logic                  last_pop;

  assign pop        = m_valid & m_ready;
  assign last_pop   = pop & (head.idx == LAST_IDX);
  assign credit_sum = {1'b0, occ} + {2'b0, inflight_q};
  // occ + inflight - pop < 2, rearranged to stay unsigned
  assign issue_ok   = credit_sum < (3'd2 + {2'b0, pop});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (rf_ren && rd_cnt_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    rf_ren = (state_q == READ) && issue_ok;
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (state_q == IDLE && start) begin
      rd_cnt_d = '0;
    end else if (rf_ren) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      raddr_q    <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      if (rf_ren) begin
        raddr_q <= rd_cnt_q;
      end
      tag_q      <= rf_raddr;
      inflight_q <= rf_ren;
      done_q     <= (state_q == DRAIN) && last_pop;
    end
  end

  assign rf_raddr = rf_ren ? rd_cnt_q : raddr_q;

  // Read data lands one cycle after the enable, tagged with that read's address.
  assign push_beat.re  = rf_dout_real;
  assign push_beat.im  = rf_dout_imag;
  assign push_beat.idx = tag_q;

  da_skid_fifo u_fifo (
    .clk_i   (clk),
    .clr_i   (rst),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (push_beat),
    .head_o  (head),
    .count_o (occ),
    .empty_o (empty)
  );

  assign m_valid = ~empty;
  assign m_real  = m_valid ? head.re  : '0;
  assign m_imag  = m_valid ? head.im  : '0;
  assign m_index = m_valid ? head.idx : '0;
  assign m_last  = m_valid && (head.idx == LAST_IDX);
  assign done    = done_q;

endmodule
